lcd_grid_streamer: RTL

Parametrised game-grid to LCD byte streamer. It snapshots a ROWS×COLS occupancy table, scales each cell to a 2^CELL_SHIFT pixel square at a programmable offset, and emits one full frame of vertical 8-pixel page bytes in page-major order. The byte stream and its addressing tags feed the LCD panel controller through a valid/accept handshake, so the two-half (CS) 128×64 panel is covered without a RAM.

---
 rtl/lcd_pkg.sv | 20 ++
 rtl/lcd_page_byte.sv | 68 ++++++
 rtl/lcd_grid_streamer.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD grid streamer: FSM states, panel constants
// and the occupancy-table indexing helper.
package lcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LATCH,
        ST_GEN,
        ST_HOLD
    } state_e;

    localparam int LCD_WIDTH     = 128;
    localparam int LCD_NUM_PAGES = 8;
    localparam int LCD_HALF_W    = LCD_WIDTH / 2;

    function automatic int cell_index(input int gy, input int gx, input int cols);
        return gy * cols + gx;
    endfunction

endpackage

// File: rtl/lcd_page_byte.sv
// Combinational (page, x) -> 8-pixel column byte from the shadowed grid.
// Optional macro GRID_BORDER_EN draws a 1-pixel frame around the grid.
module lcd_page_byte
    import lcd_pkg::*;
#(
    parameter int GRID_ROWS  = 10,
    parameter int GRID_COLS  = 10,
    parameter int CELL_SHIFT = 2,
    parameter int X_OFF      = 32,
    parameter int Y_OFF      = 8,
    parameter int LCD_W      = LCD_WIDTH,
    parameter int LCD_PAGES  = LCD_NUM_PAGES
) (
    input  logic [GRID_ROWS*GRID_COLS-1:0] shadow,
    input  logic                           invert,
    input  logic [$clog2(LCD_PAGES)-1:0]   page,
    input  logic [$clog2(LCD_W)-1:0]       x,
    output logic [7:0]                     byte_out
);

    localparam int N  = GRID_ROWS * GRID_COLS;
    localparam int IW = $clog2(N);
    localparam int XW = $clog2(LCD_W);
    localparam int YW = $clog2(LCD_PAGES) + 3;

    // The extra top bit of dx/dy flags a pixel left of / above the grid.
    function automatic logic pixel_lit(input logic [N-1:0] tbl,
                                       input logic [YW-1:0] py,
                                       input logic [XW-1:0] px);
        logic [XW:0] dx;
        logic [YW:0] dy;
        int          gx;
        int          gy;
        logic        lit;
        dx  = {1'b0, px} - (XW+1)'(X_OFF);
        dy  = {1'b0, py} - (YW+1)'(Y_OFF);
        gx  = int'(dx >> CELL_SHIFT);
        gy  = int'(dy >> CELL_SHIFT);
        lit = 1'b0;
        if (!dx[XW] && !dy[YW] && gx < GRID_COLS && gy < GRID_ROWS)
            lit = tbl[IW'(cell_index(gy, gx, GRID_COLS))];
`ifdef GRID_BORDER_EN
        begin
            int xi, yi, x_lo, x_hi, y_lo, y_hi;
            xi   = int'(px);
            yi   = int'(py);
            x_lo = X_OFF - 1;
            x_hi = X_OFF + (GRID_COLS << CELL_SHIFT);
            y_lo = Y_OFF - 1;
            y_hi = Y_OFF + (GRID_ROWS << CELL_SHIFT);
            if (((xi == x_lo || xi == x_hi) && yi >= y_lo && yi <= y_hi) ||
                ((yi == y_lo || yi == y_hi) && xi >= x_lo && xi <= x_hi))
                lit = 1'b1;
        end
`endif
        return lit;
    endfunction

    logic [7:0] lit_byte;

    always_comb begin
        lit_byte = '0;
        for (int b = 0; b < 8; b++)
            lit_byte[b] = pixel_lit(shadow, {page, 3'(b)}, x);
        byte_out = lit_byte ^ {8{invert}};
    end

endmodule

// File: rtl/lcd_grid_streamer.sv
// Streams one full LCD frame of page bytes rendered from a snapshotted grid.
// Optional macro GRID_BORDER_EN (in lcd_page_byte) adds a grid border.
module lcd_grid_streamer
    import lcd_pkg::*;
#(
    parameter int GRID_ROWS  = 10,
    parameter int GRID_COLS  = 10,
    parameter int CELL_SHIFT = 2,
    parameter int X_OFF      = 32,
    parameter int Y_OFF      = 8,
    parameter int LCD_W      = LCD_WIDTH,
    parameter int LCD_PAGES  = LCD_NUM_PAGES
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [GRID_ROWS*GRID_COLS-1:0] game_table,
    input  logic                           change,
    input  logic                           invert,
    input  logic                           en_tran,
    output logic [7:0]                     data_out,
    output logic                           data_valid,
    output logic [$clog2(LCD_PAGES)-1:0]   page,
    output logic [$clog2(LCD_W)-2:0]       col_addr,
    output logic                           cs_sel,
    output logic                           busy,
    output logic                           frame_done
);

    localparam int N  = GRID_ROWS * GRID_COLS;
    localparam int XW = $clog2(LCD_W);
    localparam int PW = $clog2(LCD_PAGES);

    state_e         state_q, state_d;
    logic [N-1:0]   shadow_q, shadow_d;
    logic           invert_q, invert_d;
    logic [XW-1:0]  x_q, x_d;
    logic [PW-1:0]  page_q, page_d;
    logic [7:0]     data_q, data_d;
    logic           valid_q, valid_d;
    logic           pending_q, pending_d;
    logic           done_q, done_d;
    logic [7:0]     gen_byte;

    lcd_page_byte #(
        .GRID_ROWS (GRID_ROWS),
        .GRID_COLS (GRID_COLS),
        .CELL_SHIFT(CELL_SHIFT),
        .X_OFF     (X_OFF),
        .Y_OFF     (Y_OFF),
        .LCD_W     (LCD_W),
        .LCD_PAGES (LCD_PAGES)
    ) u_page_byte (
        .shadow  (shadow_q),
        .invert  (invert_q),
        .page    (page_q),
        .x       (x_q),
        .byte_out(gen_byte)
    );

    always_comb begin
        // NOTE: every _d gets its hold value first so no path infers a latch.
        state_d   = state_q;
        shadow_d  = shadow_q;
        invert_d  = invert_q;
        x_d       = x_q;
        page_d    = page_q;
        data_d    = data_q;
        valid_d   = valid_q;
        pending_d = pending_q;
        done_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (change || pending_q) state_d = ST_LATCH;
            end
            ST_LATCH: begin
                shadow_d  = game_table;
                invert_d  = invert;
                x_d       = '0;
                page_d    = '0;
                pending_d = 1'b0;
                state_d   = ST_GEN;
            end
            ST_GEN: begin
                data_d  = gen_byte;
                valid_d = 1'b1;
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (en_tran) begin
                    valid_d = 1'b0;
                    state_d = ST_GEN;
                    if (x_q == XW'(LCD_W - 1)) begin
                        x_d = '0;
                        if (page_q == PW'(LCD_PAGES - 1)) begin
                            page_d  = '0;
                            done_d  = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            page_d = page_q + 1'b1;
                        end
                    end else begin
                        x_d = x_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // A request seen while busy (LATCH included) queues exactly one more frame.
        if (state_q != ST_IDLE && change) pending_d = 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments only; the shadow is
    // plain flops, so it is reset along with everything else.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            shadow_q  <= '0;
            invert_q  <= 1'b0;
            x_q       <= '0;
            page_q    <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            pending_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shadow_q  <= shadow_d;
            invert_q  <= invert_d;
            x_q       <= x_d;
            page_q    <= page_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            pending_q <= pending_d;
            done_q    <= done_d;
        end
    end

    assign data_out   = data_q;
    assign data_valid = valid_q;
    assign page       = page_q;
    assign col_addr   = x_q[XW-2:0];
    assign cs_sel     = x_q[XW-1];
    assign busy       = (state_q != ST_IDLE);
    assign frame_done = done_q;

endmodule
